// File: rtl/riscv_pkg.sv
// Shared defaults and types for the RISC-V integer register file and scoreboard.
package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int NREGS          = 32;
    localparam int REGISTER_PORTS = 4;
    localparam int REG_TAG_W      = 4;
    localparam int AW             = $clog2(NREGS);

    typedef logic [AW-1:0]        reg_addr_t;
    typedef logic [REG_TAG_W-1:0] reg_tag_t;
    typedef logic [XLEN-1:0]      reg_data_t;

    // x0 is hardwired and addresses past the last register do not exist.
    function automatic logic reg_addr_ok(input int addr, input int nregs);
        return (addr != 0) && (addr < nregs);
    endfunction

endpackage

// File: rtl/riscv_reg_sb_if.sv
// Issue/writeback/decode bundle of the scoreboarded register file.
interface riscv_reg_sb_if #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int NREGS       = riscv_pkg::NREGS,
    parameter int WRITE_PORTS = 2,
    parameter int LOCK_PORTS  = 2,
    parameter int READ_PORTS  = riscv_pkg::REGISTER_PORTS,
    parameter int TAG_W       = riscv_pkg::REG_TAG_W
);
    localparam int AW = $clog2(NREGS);

    logic [LOCK_PORTS-1:0]                 lock_en;
    logic [LOCK_PORTS-1:0][AW-1:0]         lock_addr;
    logic [LOCK_PORTS-1:0][TAG_W-1:0]      lock_tag;
    logic [WRITE_PORTS-1:0]                write_en;
    logic [WRITE_PORTS-1:0][AW-1:0]        write_addr;
    logic [WRITE_PORTS-1:0][TAG_W-1:0]     write_tag;
    logic [WRITE_PORTS-1:0][XLEN-1:0]      write_data;
    logic [READ_PORTS-1:0][AW-1:0]         read_addr;
    logic [READ_PORTS-1:0][XLEN-1:0]       read_data;
    logic [READ_PORTS-1:0]                 read_locked;
    logic [NREGS-1:0][XLEN-1:0]            register;
    logic [NREGS-1:0]                      register_locked;
    logic [NREGS-1:0][TAG_W-1:0]           register_tag;
    logic                                  write_conflict;

    modport master (
        output lock_en, lock_addr, lock_tag,
        output write_en, write_addr, write_tag, write_data,
        output read_addr,
        input  read_data, read_locked,
        input  register, register_locked, register_tag, write_conflict
    );

    modport slave (
        input  lock_en, lock_addr, lock_tag,
        input  write_en, write_addr, write_tag, write_data,
        input  read_addr,
        output read_data, read_locked,
        output register, register_locked, register_tag, write_conflict
    );

endinterface

// File: rtl/riscv_reg_sb_read.sv
// One combinational decode read port. Same-cycle write bypass is built when
// RISCV_REG_BYPASS_EN is defined.
module riscv_reg_sb_read #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int NREGS       = riscv_pkg::NREGS,
    parameter int WRITE_PORTS = 2,
    parameter int TAG_W       = riscv_pkg::REG_TAG_W,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic [AW-1:0]                     read_addr,
    input  logic [NREGS-1:0][XLEN-1:0]        register,
    input  logic [NREGS-1:0]                  register_locked,
`ifdef RISCV_REG_BYPASS_EN
    input  logic [NREGS-1:0][TAG_W-1:0]       register_tag,
    input  logic [WRITE_PORTS-1:0]            write_en,
    input  logic [WRITE_PORTS-1:0][AW-1:0]    write_addr,
    input  logic [WRITE_PORTS-1:0][TAG_W-1:0] write_tag,
    input  logic [WRITE_PORTS-1:0][XLEN-1:0]  write_data,
`endif
    output logic [XLEN-1:0]                   read_data,
    output logic                              read_locked
);
    import riscv_pkg::*;

    always_comb begin
        read_data   = '0;
        read_locked = 1'b0;
        if (reg_addr_ok(int'(read_addr), NREGS)) begin
            read_data   = register[read_addr];
            read_locked = register_locked[read_addr];
`ifdef RISCV_REG_BYPASS_EN
            // Ascending loop so the highest matching write port wins.
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (write_en[w] && (write_addr[w] == read_addr)) begin
                    read_data   = write_data[w];
                    read_locked = (write_tag[w] == register_tag[read_addr]) ?
                                  1'b0 : register_locked[read_addr];
                end
            end
`endif
        end
    end

endmodule

// File: rtl/riscv_reg_sb.sv
// Integer register file with tagged lock scoreboard for issue/writeback.
// Define RISCV_REG_BYPASS_EN to forward same-cycle writes to the read ports.
module riscv_reg_sb #(
    parameter int XLEN        = riscv_pkg::XLEN,
    parameter int NREGS       = riscv_pkg::NREGS,
    parameter int WRITE_PORTS = 2,
    parameter int LOCK_PORTS  = 2,
    parameter int READ_PORTS  = riscv_pkg::REGISTER_PORTS,
    parameter int TAG_W       = riscv_pkg::REG_TAG_W
) (
    input logic           clock,
    input logic           reset,
    riscv_reg_sb_if.slave bus
);
    import riscv_pkg::*;

    logic [NREGS-1:0][XLEN-1:0]  register_d, register_q;
    logic [NREGS-1:0]            locked_d, locked_q;
    logic [NREGS-1:0][TAG_W-1:0] tag_d, tag_q;
    logic                        write_conflict_d, write_conflict_q;

    // Writes first, then locks, so a same-cycle lock beats a lock release.
    // Each write re-evaluates the release from registered state, so the
    // highest port index decides both data and the tag compare.
    always_comb begin
        register_d       = register_q;
        locked_d         = locked_q;
        tag_d            = tag_q;
        write_conflict_d = 1'b0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (bus.write_en[w] && reg_addr_ok(int'(bus.write_addr[w]), NREGS)) begin
                register_d[bus.write_addr[w]] = bus.write_data[w];
                locked_d[bus.write_addr[w]]   = locked_q[bus.write_addr[w]] &&
                    (bus.write_tag[w] != tag_q[bus.write_addr[w]]);
            end
        end
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int j = i + 1; j < WRITE_PORTS; j++) begin
                if (bus.write_en[i] && bus.write_en[j] &&
                    (bus.write_addr[i] == bus.write_addr[j]) &&
                    reg_addr_ok(int'(bus.write_addr[i]), NREGS)) begin
                    write_conflict_d = 1'b1;
                end
            end
        end
        for (int l = 0; l < LOCK_PORTS; l++) begin
            if (bus.lock_en[l] && reg_addr_ok(int'(bus.lock_addr[l]), NREGS)) begin
                locked_d[bus.lock_addr[l]] = 1'b1;
                tag_d[bus.lock_addr[l]]    = bus.lock_tag[l];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            register_q       <= '0;
            locked_q         <= '0;
            tag_q            <= '0;
            write_conflict_q <= 1'b0;
        end else begin
            register_q       <= register_d;
            locked_q         <= locked_d;
            tag_q            <= tag_d;
            write_conflict_q <= write_conflict_d;
        end
    end

    assign bus.register        = register_q;
    assign bus.register_locked = locked_q;
    assign bus.register_tag    = tag_q;
    assign bus.write_conflict  = write_conflict_q;

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_read
        riscv_reg_sb_read #(
            .XLEN        (XLEN),
            .NREGS       (NREGS),
            .WRITE_PORTS (WRITE_PORTS),
            .TAG_W       (TAG_W)
        ) u_read (
            .read_addr       (bus.read_addr[r]),
            .register        (register_q),
            .register_locked (locked_q),
`ifdef RISCV_REG_BYPASS_EN
            .register_tag    (tag_q),
            .write_en        (bus.write_en),
            .write_addr      (bus.write_addr),
            .write_tag       (bus.write_tag),
            .write_data      (bus.write_data),
`endif
            .read_data       (bus.read_data[r]),
            .read_locked     (bus.read_locked[r])
        );
    end

endmodule

// File: tb/tb_riscv_reg_sb.sv
// Directed self-checking bench for riscv_reg_sb; expectations follow
// RISCV_REG_BYPASS_EN when it is defined.
module tb_riscv_reg_sb;

    logic clock = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    riscv_reg_sb_if bus ();

    riscv_reg_sb dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    task automatic apply_idle();
        bus.lock_en    = '0;
        bus.lock_addr  = '0;
        bus.lock_tag   = '0;
        bus.write_en   = '0;
        bus.write_addr = '0;
        bus.write_tag  = '0;
        bus.write_data = '0;
    endtask

    task automatic apply_lock(input int port, input logic [4:0] addr, input logic [3:0] tag);
        bus.lock_en[port]   = 1'b1;
        bus.lock_addr[port] = addr;
        bus.lock_tag[port]  = tag;
    endtask

    task automatic apply_write(input int port, input logic [4:0] addr, input logic [3:0] tag,
                               input logic [31:0] data);
        bus.write_en[port]   = 1'b1;
        bus.write_addr[port] = addr;
        bus.write_tag[port]  = tag;
        bus.write_data[port] = data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        $display("[TB] riscv_reg_sb directed test");
        apply_idle();
        bus.read_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_output("reset_regs_zero", 64'(bus.register == '0), 64'd1);
        check_output("reset_locked", 64'(bus.register_locked), 64'd0);
        check_output("reset_conflict", 64'(bus.write_conflict), 64'd0);

        // Lock r5 tag 3, then matching writeback releases it
        apply_lock(0, 5'd5, 4'd3);
        tick();
        apply_idle();
        check_output("r5_locked", 64'(bus.register_locked[5]), 64'd1);
        check_output("r5_tag", 64'(bus.register_tag[5]), 64'd3);
        apply_write(0, 5'd5, 4'd3, 32'hDEADBEEF);
        tick();
        apply_idle();
        check_output("r5_data", 64'(bus.register[5]), 64'hDEADBEEF);
        check_output("r5_unlocked", 64'(bus.register_locked[5]), 64'd0);

        // Relock r7 with a younger tag; stale writeback keeps the lock
        apply_lock(1, 5'd7, 4'd1);
        tick();
        apply_lock(1, 5'd7, 4'd2);
        tick();
        apply_write(1, 5'd7, 4'd1, 32'h11);
        tick();
        apply_idle();
        check_output("r7_stale_data", 64'(bus.register[7]), 64'h11);
        check_output("r7_stale_locked", 64'(bus.register_locked[7]), 64'd1);
        check_output("r7_stale_tag", 64'(bus.register_tag[7]), 64'd2);
        apply_write(0, 5'd7, 4'd2, 32'h22);
        tick();
        apply_idle();
        check_output("r7_release", 64'(bus.register_locked[7]), 64'd0);
        check_output("r7_data", 64'(bus.register[7]), 64'h22);

        // Same-cycle matching write and lock on r9: lock wins
        apply_lock(0, 5'd9, 4'd4);
        tick();
        apply_write(1, 5'd9, 4'd4, 32'h99);
        apply_lock(0, 5'd9, 4'd6);
        tick();
        apply_idle();
        check_output("r9_data", 64'(bus.register[9]), 64'h99);
        check_output("r9_locked", 64'(bus.register_locked[9]), 64'd1);
        check_output("r9_tag", 64'(bus.register_tag[9]), 64'd6);
        check_output("r9_no_conflict", 64'(bus.write_conflict), 64'd0);

        // Two writes to r3: port 1 wins, one-cycle conflict pulse
        apply_write(0, 5'd3, 4'd0, 32'hA);
        apply_write(1, 5'd3, 4'd0, 32'hB);
        tick();
        apply_idle();
        check_output("r3_data", 64'(bus.register[3]), 64'hB);
        check_output("r3_conflict", 64'(bus.write_conflict), 64'd1);
        tick();
        check_output("r3_conflict_drop", 64'(bus.write_conflict), 64'd0);

        // Two locks to r10: port 1 wins the tag
        apply_lock(0, 5'd10, 4'd1);
        apply_lock(1, 5'd10, 4'd5);
        tick();
        apply_idle();
        check_output("r10_tag", 64'(bus.register_tag[10]), 64'd5);

        // Two writes to r11, low port matches tag, high port stale: stays locked
        apply_lock(0, 5'd11, 4'd7);
        tick();
        apply_write(0, 5'd11, 4'd7, 32'h1);
        apply_write(1, 5'd11, 4'd2, 32'h2);
        tick();
        apply_idle();
        check_output("r11_data", 64'(bus.register[11]), 64'h2);
        check_output("r11_locked", 64'(bus.register_locked[11]), 64'd1);
        check_output("r11_conflict", 64'(bus.write_conflict), 64'd1);

        // Combinational reads of settled state
        bus.read_addr[1] = 5'd5;
        bus.read_addr[2] = 5'd9;
        #1;
        check_output("rd_r5_data", 64'(bus.read_data[1]), 64'hDEADBEEF);
        check_output("rd_r5_locked", 64'(bus.read_locked[1]), 64'd0);
        check_output("rd_r9_locked", 64'(bus.read_locked[2]), 64'd1);

        // Same-cycle write and read of locked r4
        apply_lock(0, 5'd4, 4'd2);
        tick();
        apply_idle();
        apply_write(0, 5'd4, 4'd2, 32'h1234);
        bus.read_addr[0] = 5'd4;
        #1;
`ifdef RISCV_REG_BYPASS_EN
        check_output("byp_r4_data", 64'(bus.read_data[0]), 64'h1234);
        check_output("byp_r4_locked", 64'(bus.read_locked[0]), 64'd0);
`else
        check_output("nobyp_r4_data", 64'(bus.read_data[0]), 64'h0);
        check_output("nobyp_r4_locked", 64'(bus.read_locked[0]), 64'd1);
`endif
        tick();
        apply_idle();
        check_output("r4_read_data", 64'(bus.read_data[0]), 64'h1234);
        check_output("r4_read_locked", 64'(bus.read_locked[0]), 64'd0);

        // x0 ignores writes and locks
        apply_write(0, 5'd0, 4'd3, 32'h55);
        apply_lock(0, 5'd0, 4'd3);
        bus.read_addr[3] = 5'd0;
        tick();
        apply_idle();
        check_output("r0_data", 64'(bus.register[0]), 64'h0);
        check_output("r0_locked", 64'(bus.register_locked[0]), 64'd0);
        check_output("r0_read_data", 64'(bus.read_data[3]), 64'h0);
        check_output("r0_read_locked", 64'(bus.read_locked[3]), 64'd0);

        // Reset with r2 locked, overriding a same-cycle write and lock
        apply_lock(0, 5'd2, 4'd1);
        tick();
        apply_idle();
        check_output("r2_locked", 64'(bus.register_locked[2]), 64'd1);
        reset = 1'b1;
        apply_write(0, 5'd6, 4'd1, 32'h66);
        apply_lock(1, 5'd6, 4'd5);
        tick();
        reset = 1'b0;
        apply_idle();
        check_output("rst_regs_zero", 64'(bus.register == '0), 64'd1);
        check_output("rst_locked", 64'(bus.register_locked), 64'd0);
        check_output("rst_tags_zero", 64'(bus.register_tag == '0), 64'd1);
        check_output("rst_conflict", 64'(bus.write_conflict), 64'd0);

        // Post-reset writeback only updates data
        apply_write(0, 5'd2, 4'd1, 32'h77);
        tick();
        apply_idle();
        check_output("r2_post_data", 64'(bus.register[2]), 64'h77);
        check_output("r2_post_locked", 64'(bus.register_locked[2]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_reg_sb.md
# riscv_reg_sb

Parametrised integer register file with tagged scoreboard, for the RISC-V core's issue/writeback stage. Issue locks a destination register with a tag; writeback updates data and releases the lock only when its tag matches the latest lock. This keeps an older writeback from unlocking a register that a younger instruction has re-locked. Combinational read ports return data and lock state to the decoder, with optional same-cycle write bypass.

## Interface
- `XLEN`, 32, data width.
- `NREGS`, 32, architectural registers; `AW = $clog2(NREGS)`.
- `WRITE_PORTS`, 2, writeback ports.
- `LOCK_PORTS`, 2, issue lock ports.
- `READ_PORTS`, 4, read ports.
- `TAG_W`, 4, lock tag width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `lock_en` in `[LOCK_PORTS]`: lock request per port.
- `lock_addr` in `[LOCK_PORTS][AW]`: register to lock.
- `lock_tag` in `[LOCK_PORTS][TAG_W]`: tag of locking instruction.
- `write_en` in `[WRITE_PORTS]`: writeback valid.
- `write_addr` in `[WRITE_PORTS][AW]`: destination register.
- `write_tag` in `[WRITE_PORTS][TAG_W]`: tag of writing instruction.
- `write_data` in `[WRITE_PORTS][XLEN]`: result.
- `read_addr` in `[READ_PORTS][AW]`: source register.
- `read_data` out `[READ_PORTS][XLEN]`: source value.
- `read_locked` out `[READ_PORTS]`: source not yet available.
- `register` out `[NREGS][XLEN]`: full array, registered.
- `register_locked` out `[NREGS]`: lock bits, registered.
- `register_tag` out `[NREGS][TAG_W]`: current lock tag per register.
- `write_conflict` out 1: one-cycle pulse when two write ports hit the same nonzero register.

## Operation
- Register 0 is hardwired zero and never locked. Writes and locks to address 0 are ignored. `read_data` is 0 and `read_locked` is 0 for address 0.
- Write on port n (nonzero addr): data always updates next cycle. The lock clears only if `register_locked` is set and `write_tag == register_tag`. On tag mismatch (stale write), the lock and tag are unchanged.
- Lock on port n (nonzero addr): next cycle, locked=1 and tag=`lock_tag`.
- Same register, same cycle:
  - Lock overrides the write's lock release, so the register ends locked with the new tag. The data write still lands.
  - Multiple writes: the highest port index wins data and tag compare, and `write_conflict` pulses the next cycle.
  - Multiple locks: the highest port index wins the tag.
- Reads are combinational from the registered array, unless bypass is enabled (see Configuration).
- Addresses at or above `NREGS` (when `NREGS` is not a power of two) are ignored for write and lock. Reads of such addresses return 0, unlocked.

## Timing
- Write and lock take effect at the next rising edge. The registered outputs reflect them one cycle after the request.
- Read latency: 0 cycles, combinational.
- Reset: on the clock edge with `reset=1`, `register`, `register_locked`, `register_tag` and `write_conflict` all clear to 0. Reset overrides any same-cycle write or lock.
- Reset mid-operation drops all outstanding locks. Post-reset writebacks carrying any tag only update data, since nothing is locked.

## Configuration
- `RISCV_REG_BYPASS_EN` defined:
  - A read whose address matches a same-cycle nonzero write returns that `write_data` (highest matching port).
  - `read_locked` reports 0 when that write's tag matches the current lock tag, otherwise the current lock bit.
  - A same-cycle lock is not visible to reads.
- Undefined: reads see registered state only, so a write is visible one cycle later.

## Structure
- `riscv_pkg` gets:
  - Defaults `XLEN`, `NREGS`, `REGISTER_PORTS`, `REG_TAG_W`.
  - Typedefs `reg_addr_t` (`logic [AW-1:0]`), `reg_tag_t`, `reg_data_t`.
- Sub-module `riscv_reg_sb_read`, one instance per read port. It holds the address decode, the x0 forcing, and the bypass mux under the macro.

## Test plan
- Lock r5 with tag 3. The next cycle, write r5 with tag 3 and data 0xDEADBEEF. Required: `register[5]=0xDEADBEEF`, `register_locked[5]=0`.
- Lock r7 with tag 1, then lock r7 with tag 2, then write r7 with tag 1 and data 0x11. Required: data=0x11, still locked, tag=2. Then write with tag 2. Required: unlocked.
- Same cycle: write r9 with tag 4 (r9 locked with tag 4) and lock r9 with tag 6. Required: data updated, locked=1, tag=6.
- Write ports 0 and 1 both to r3, with data 0xA and 0xB. Required: `register[3]=0xB`, `write_conflict=1` for exactly one cycle.
- Write r0 with 0x55 and lock r0. Required: `register[0]=0`, `read_data=0`, no lock. Then assert reset while r2 is locked. Required: all outputs 0 next cycle.
- With `RISCV_REG_BYPASS_EN`: write r4 with 0x1234 and tag 2 (r4 locked with tag 2) while reading r4. Required: `read_data=0x1234`, `read_locked=0` the same cycle. Without the macro: old data and locked=1.
